iram_fetch_arbiter: RTL and testbench
=====================================

# iram_fetch_arbiter

Owns the single-port JVM bytecode RAM (iram) and shares it between the translator's byte-fetch port and the host bytecode loader. Maintains the bytecode program counter and issues one synchronous RAM read or write at a time. Drives `waiting` to stall the translator state machine while a fetch is outstanding. Arbitrates fetch vs. load with alternating priority and supports PC redirect with abort of an in-flight read.

## Interface
- `ADDR_W`, 10, iram address width; the PC is also this width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  level request from the translator for the byte at `pc`.
- `fetch_data`  out  8  last fetched byte; holds until the next capture.
- `fetch_valid`  out  1  one-cycle pulse: `fetch_data` is new, `pc` has advanced.
- `waiting`  out  1  combinational `fetch_req & ~fetch_valid`; stalls the translator.
- `pc_load`  in  1  PC redirect strobe.
- `pc_load_value`  in  ADDR_W  new PC.
- `pc`  out  ADDR_W  current bytecode PC.
- `pc_wrap`  out  1  sticky; set when `pc` increments from all-ones to 0.
- `load_req`  in  1  host write request (level).
- `load_adr`  in  ADDR_W  host write address.
- `load_data`  in  8  host write byte.
- `load_gnt`  out  1  one-cycle pulse, high in the cycle the write is performed.
- `ram_adr`  out  ADDR_W  iram address (registered).
- `ram_we`  out  1  iram write enable (registered).
- `ram_wdata`  out  8  iram write data (registered).
- `ram_rdata`  in  8  iram read data; valid the cycle after the address cycle.

## Operation
- States: IDLE, READ, CAPTURE, WRITE. `last_gnt` register: 0 = fetch served last, 1 = load served last.
- IDLE: eligible fetch = `fetch_req & ~fetch_valid`; eligible load = `load_req & ~load_gnt`.
  - Only one eligible: grant it.
  - Both eligible: grant the side opposite to `last_gnt`.
  - Fetch grant: `ram_adr<=pc`, `ram_we<=0`, `last_gnt<=0`, go to READ.
  - Load grant: `ram_adr<=load_adr`, `ram_wdata<=load_data`, `ram_we<=1`, `load_gnt<=1`, `last_gnt<=1`, go to WRITE.
- READ: RAM samples the address. Go to CAPTURE.
- CAPTURE: `fetch_data<=ram_rdata`, `fetch_valid<=1`, `pc<=pc+1` (mod 2^ADDR_W), go to IDLE.
- WRITE: RAM performs the write. `ram_we<=0`, `load_gnt<=0`, go to IDLE.
- `fetch_valid` and `load_gnt` are cleared on every cycle in which they are not set.
- `pc_load` has top priority over everything in any state:
  - `pc<=pc_load_value` and `pc_wrap<=0`.
  - In READ or CAPTURE: the read is aborted. State goes to IDLE; no `fetch_valid`, no PC increment.
  - In WRITE: the write completes normally.
  - In IDLE: no grant is issued that cycle; load and fetch wait for the next cycle.
- `pc_wrap` is set when CAPTURE increments `pc` from 2^ADDR_W-1. It is cleared only by `pc_load` or reset.
- Requesters hold `req`, address and data stable until their pulse (`fetch_valid` or `load_gnt`). Holding `req` after the pulse requests the next transfer.

## Timing
- Reset (async, while `reset`=0): state IDLE, `pc`=0, `pc_wrap`=0, `last_gnt`=1 (fetch wins the first conflict), `fetch_data`=0, `fetch_valid`=0, `load_gnt`=0, `ram_adr`=0, `ram_we`=0, `ram_wdata`=0.
  - Reset mid-write drops `ram_we` immediately.
  - Reset mid-read discards the read.
- Fetch latency: `fetch_req` sampled in IDLE at edge T; `fetch_valid`=1 during cycle T+3.
  - Back-to-back fetches: one byte per 4 cycles.
- Write: `load_req` sampled at edge T; `ram_we` and `load_gnt` high during cycle T+1 only.
  - Back-to-back loads: one byte per 2 cycles.
- Under continuous contention, grants alternate: fetch, load, fetch, …
- `waiting` is high from the cycle `fetch_req` rises until the `fetch_valid` cycle, where it is 0.

## Test plan
- Reset, then `fetch_req` held with iram[0..2]=0x10,0x15,0xB1 -> `fetch_valid` pulses every 4 cycles with 0x10, 0x15, 0xB1; `pc` steps 1, 2, 3; `waiting` is low only in the pulse cycles.
- `load_req` with adr 0x005, data 0xC4, no fetch -> `ram_we`/`load_gnt` high for exactly 1 cycle with `ram_adr`=0x005, `ram_wdata`=0xC4; a later fetch at pc 5 returns 0xC4.
- `fetch_req` and `load_req` both held from reset -> grant order fetch, load, fetch, load; neither side starves over 20 transfers.
- `pc_load`=1 with value 0x100 in the CAPTURE cycle of a fetch -> no `fetch_valid`, `pc`=0x100; the next fetch returns iram[0x100]. `pc_load` during WRITE -> the write still lands.
- `pc_load` 0x3FF then one fetch -> `pc`=0x000, `pc_wrap`=1; a subsequent `pc_load` clears `pc_wrap`.
- Assert `reset` low in the WRITE cycle -> `ram_we` and `load_gnt` drop asynchronously; all outputs return to reset values.

Source files
------------

// File: rtl/iram_fetch_arbiter.sv
// Shares the single-port bytecode RAM between translator byte fetch and host loader; owns the bytecode PC.
// Fetch: grant edge T, fetch_valid during cycle T+3 (1 byte / 4 cycles); load: ram_we/load_gnt during cycle T+1.
// Requesters hold req/addr/data until their pulse; waiting stalls the translator while a fetch is pending.
module iram_fetch_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  output logic [7:0]        fetch_data,
  output logic              fetch_valid,
  output logic              waiting,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_wrap,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_adr,
  input  logic [7:0]        load_data,
  output logic              load_gnt,
  output logic [ADDR_W-1:0] ram_adr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] WRITE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_wrap_q, pc_wrap_d;
  logic              last_gnt_q, last_gnt_d;   // 0: fetch served last, 1: load served last
  logic [7:0]        fetch_data_q, fetch_data_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              load_gnt_q, load_gnt_d;
  logic [ADDR_W-1:0] ram_adr_q, ram_adr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;

  logic fetch_elig;
  logic load_elig;
  logic pick_load;

  // A requester whose pulse is showing this cycle is not yet asking for its next transfer.
  assign fetch_elig = fetch_req & ~fetch_valid_q;
  assign load_elig  = load_req & ~load_gnt_q;
  // On conflict the side that was not served last wins.
  assign pick_load  = load_elig & (~fetch_elig | ~last_gnt_q);

  // Next-state: arbitration, RAM sequencing, PC update with redirect taking precedence.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_wrap_d     = pc_wrap_q;
    last_gnt_d    = last_gnt_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    load_gnt_d    = 1'b0;
    ram_adr_d     = ram_adr_q;
    ram_we_d      = 1'b0;
    ram_wdata_d   = ram_wdata_q;

    case (state_q)
      IDLE: begin
        // A redirect cycle issues no grant; requesters retry next cycle.
        if (!pc_load) begin
          if (pick_load) begin
            ram_adr_d   = load_adr;
            ram_wdata_d = load_data;
            ram_we_d    = 1'b1;
            load_gnt_d  = 1'b1;
            last_gnt_d  = 1'b1;
            state_d     = WRITE;
          end else if (fetch_elig) begin
            ram_adr_d  = pc_q;
            last_gnt_d = 1'b0;
            state_d    = READ;
          end
        end
      end
      READ: begin
        state_d = pc_load ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        // Redirect aborts the read: the byte belongs to the old PC stream.
        if (!pc_load) begin
          fetch_data_d  = ram_rdata;
          fetch_valid_d = 1'b1;
          pc_d          = pc_q + ADDR_W'(1);
          if (&pc_q) begin
            pc_wrap_d = 1'b1;
          end
        end
        state_d = IDLE;
      end
      default: begin
        // WRITE: the RAM commits this cycle regardless of a redirect.
        state_d = IDLE;
      end
    endcase

    if (pc_load) begin
      pc_d      = pc_load_value;
      pc_wrap_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      pc_wrap_q     <= 1'b0;
      last_gnt_q    <= 1'b1;
      fetch_data_q  <= 8'h00;
      fetch_valid_q <= 1'b0;
      load_gnt_q    <= 1'b0;
      ram_adr_q     <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_wrap_q     <= pc_wrap_d;
      last_gnt_q    <= last_gnt_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      load_gnt_q    <= load_gnt_d;
      ram_adr_q     <= ram_adr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
    end
  end

  assign waiting     = fetch_req & ~fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign pc          = pc_q;
  assign pc_wrap     = pc_wrap_q;
  assign load_gnt    = load_gnt_q;
  assign ram_adr     = ram_adr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Directed bench for iram_fetch_arbiter with a behavioural synchronous single-port RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-derived from the RAM image loaded below.
module tb_iram_fetch_arbiter;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [7:0]  fetch_data;
  logic        fetch_valid;
  logic        waiting;
  logic        pc_load;
  logic [9:0]  pc_load_value;
  logic [9:0]  pc;
  logic        pc_wrap;
  logic        load_req;
  logic [9:0]  load_adr;
  logic [7:0]  load_data;
  logic        load_gnt;
  logic [9:0]  ram_adr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  iram [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  iram_fetch_arbiter #(.ADDR_W(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .fetch_data    (fetch_data),
    .fetch_valid   (fetch_valid),
    .waiting       (waiting),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .pc            (pc),
    .pc_wrap       (pc_wrap),
    .load_req      (load_req),
    .load_adr      (load_adr),
    .load_data     (load_data),
    .load_gnt      (load_gnt),
    .ram_adr       (ram_adr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: image preload, then synchronous write and registered read.
  initial begin
    for (int i = 0; i < 1024; i++) iram[i] = 8'h00;
    iram[0]     = 8'h10;
    iram[1]     = 8'h15;
    iram[2]     = 8'hB1;
    iram[10'h100] = 8'h77;
    iram[10'h3FF] = 8'hEE;
    ram_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (ram_we) iram[ram_adr] <= ram_wdata;
      ram_rdata <= iram[ram_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  // Waits for a fetch_valid pulse; n is ticks taken (== budget on timeout).
  task automatic wait_fv(input int budget, output int n, output logic stall_ok);
    logic done;
    n = 0;
    stall_ok = 1'b1;
    done = 1'b0;
    while (!done && n < budget) begin
      tick;
      n++;
      if (fetch_valid) done = 1'b1;
      else if (!waiting) stall_ok = 1'b0;
    end
  endtask

  int          n;
  logic        ok;
  int          nev;
  logic [19:0] ev;
  logic [7:0]  exp_b [3];

  initial begin
    exp_b = '{8'h10, 8'h15, 8'hB1};
    reset = 1'b1;
    fetch_req = 1'b0;
    pc_load = 1'b0;
    pc_load_value = '0;
    load_req = 1'b0;
    load_adr = '0;
    load_data = '0;
    #1;
    do_reset;

    chk("rst_pc", pc, 0);
    chk("rst_wrap", pc_wrap, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_fdata", fetch_data, 0);
    chk("rst_lgnt", load_gnt, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_adr", ram_adr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_waiting", waiting, 0);

    // Streaming fetch of three bytes.
    fetch_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_fv(12, n, ok);
      chk("fetch_lat", n, (k == 0) ? 3 : 4);
      chk("fetch_data", fetch_data, exp_b[k]);
      chk("fetch_pc", pc, k + 1);
      chk("fetch_stall", ok, 1);
      chk("fetch_wait_pulse", waiting, 0);
    end
    fetch_req = 1'b0;

    // Single host write, then read it back.
    load_req = 1'b1; load_adr = 10'h005; load_data = 8'hC4;
    tick;
    chk("ld_we", ram_we, 1);
    chk("ld_gnt", load_gnt, 1);
    chk("ld_adr", ram_adr, 10'h005);
    chk("ld_wdata", ram_wdata, 8'hC4);
    load_req = 1'b0;
    tick;
    chk("ld_we_drop", ram_we, 0);
    chk("ld_gnt_drop", load_gnt, 0);
    pc_load = 1'b1; pc_load_value = 10'h005;
    tick;
    pc_load = 1'b0;
    chk("ld_pcload", pc, 10'h005);
    fetch_req = 1'b1;
    wait_fv(12, n, ok);
    chk("ld_rb_lat", n, 3);
    chk("ld_rb_data", fetch_data, 8'hC4);
    chk("ld_rb_pc", pc, 10'h006);
    fetch_req = 1'b0;

    // Continuous contention from reset: fetch first, then strict alternation.
    reset = 1'b0;
    tick;
    fetch_req = 1'b1; load_req = 1'b1; load_adr = 10'h200; load_data = 8'h5A;
    tick;
    reset = 1'b1;
    nev = 0;
    ev = '0;
    for (int c = 0; c < 200 && nev < 20; c++) begin
      tick;
      if (fetch_valid) begin ev[nev] = 1'b0; nev++; end
      else if (load_gnt) begin ev[nev] = 1'b1; nev++; end
    end
    chk("cont_count", nev, 20);
    chk("cont_order", ev, 20'hAAAAA);
    chk("cont_pc", pc, 10);
    fetch_req = 1'b0; load_req = 1'b0;

    // Redirect in CAPTURE aborts the read.
    do_reset;
    fetch_req = 1'b1;
    tick;
    tick;
    pc_load = 1'b1; pc_load_value = 10'h100;
    tick;
    pc_load = 1'b0;
    chk("abort_fv", fetch_valid, 0);
    chk("abort_pc", pc, 10'h100);
    wait_fv(12, n, ok);
    chk("abort_lat", n, 3);
    chk("abort_data", fetch_data, 8'h77);
    chk("abort_pc_next", pc, 10'h101);
    fetch_req = 1'b0;

    // Redirect during WRITE lets the write land.
    load_req = 1'b1; load_adr = 10'h123; load_data = 8'h9E;
    tick;
    chk("wr_gnt", load_gnt, 1);
    load_req = 1'b0;
    pc_load = 1'b1; pc_load_value = 10'h123;
    tick;
    pc_load = 1'b0;
    chk("wr_we_drop", ram_we, 0);
    chk("wr_pc", pc, 10'h123);
    fetch_req = 1'b1;
    wait_fv(12, n, ok);
    chk("wr_rb_lat", n, 3);
    chk("wr_rb_data", fetch_data, 8'h9E);
    fetch_req = 1'b0;
    tick;

    // Redirect in IDLE blocks the grant that cycle; then PC wraps.
    fetch_req = 1'b1;
    pc_load = 1'b1; pc_load_value = 10'h3FF;
    tick;
    pc_load = 1'b0;
    chk("wrap_pcload", pc, 10'h3FF);
    wait_fv(12, n, ok);
    chk("wrap_lat", n, 3);
    chk("wrap_data", fetch_data, 8'hEE);
    chk("wrap_pc", pc, 10'h000);
    chk("wrap_flag", pc_wrap, 1);
    wait_fv(12, n, ok);
    chk("wrap_lat2", n, 4);
    chk("wrap_data2", fetch_data, 8'h10);
    chk("wrap_pc2", pc, 10'h001);
    chk("wrap_sticky", pc_wrap, 1);
    fetch_req = 1'b0;
    pc_load = 1'b1; pc_load_value = 10'h010;
    tick;
    pc_load = 1'b0;
    chk("wrap_clear", pc_wrap, 0);
    chk("wrap_clear_pc", pc, 10'h010);

    // Asynchronous reset in the WRITE cycle.
    load_req = 1'b1; load_adr = 10'h030; load_data = 8'h11;
    tick;
    chk("arst_pre_we", ram_we, 1);
    reset = 1'b0;
    #1;
    chk("arst_we", ram_we, 0);
    chk("arst_gnt", load_gnt, 0);
    chk("arst_adr", ram_adr, 0);
    chk("arst_wdata", ram_wdata, 0);
    chk("arst_fdata", fetch_data, 0);
    chk("arst_pc", pc, 0);
    load_req = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    chk("arst_idle_we", ram_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
